// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, SR/Cause field positions, exception codes.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    // SR field positions
    localparam int unsigned SR_IE_BIT  = 0;
    localparam int unsigned SR_EXL_BIT = 1;
    localparam int unsigned SR_IM_LSB  = 10;

    // Cause field positions
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_BD_BIT  = 31;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcAdEL = 5'd4,
        ExcAdES = 5'd5,
        ExcRI   = 5'd10,
        ExcOv   = 5'd12
    } exc_code_e;

    localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_req_arb.sv
// CP0 request arbiter: masks interrupts/exceptions against SR and picks the ExcCode to record.
module cp0_req_arb
    import cp0_pkg::*;
(
    input  logic       reset_i,
    input  logic [5:0] hw_int_i,
    input  logic [5:0] sr_im_i,
    input  logic       sr_ie_i,
    input  logic       sr_exl_i,
    input  logic [4:0] exc_code_i,
    output logic       int_req_o,
    output logic       exc_req_o,
    output logic       req_o,
    output logic [4:0] exc_code_next_o
);

    // Interrupt wins over a synchronous exception; EXL masks both.
    always_comb begin
        int_req_o       = (|(hw_int_i & sr_im_i)) & sr_ie_i & ~sr_exl_i;
        exc_req_o       = (exc_code_i != 5'd0) & ~sr_exl_i;
        req_o           = ~reset_i & (int_req_o | exc_req_o);
        exc_code_next_o = int_req_o ? ExcInt : exc_code_i;
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the M stage: SR/Cause/EPC, mfc0/mtc0/eret and exception request.
// Optional feature: define CP0_PRID_EN to make register 15 return PRID_VALUE.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h4A55_4C59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [29:0] epc_q, epc_d;  // EPC is always word-aligned; only [31:2] is stored

    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_code_next;
    logic [29:0] pc_word;

    cp0_req_arb u_req_arb (
        .reset_i         (reset),
        .hw_int_i        (HWInt),
        .sr_im_i         (sr_im_q),
        .sr_ie_i         (sr_ie_q),
        .sr_exl_i        (sr_exl_q),
        .exc_code_i      (ExcCodeIn),
        .int_req_o       (int_req),
        .exc_req_o       (exc_req),
        .req_o           (Req),
        .exc_code_next_o (exc_code_next)
    );

    // Delay-slot victims resume at the branch: back up one word.
    assign pc_word = PC[31:2] - {29'd0, BDIn};

    // Next-state: exception entry beats mtc0 and eret in the same cycle.
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (Req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = BDIn;
            cause_exc_d = exc_code_next;
            epc_d       = pc_word;
        end else begin
            if (WE) begin
                case (A2)
                    CP0_REG_SR: begin
                        sr_im_d  = DIn[SR_IM_LSB +: 6];
                        sr_exl_d = DIn[SR_EXL_BIT];
                        sr_ie_d  = DIn[SR_IE_BIT];
                    end
                    CP0_REG_EPC: epc_d = DIn[31:2];
                    default: ;
                endcase
            end
            if (EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // mfc0 read mux; forced to zero while reset is asserted.
    always_comb begin
        DOut = '0;
        if (!reset) begin
            case (A1)
                CP0_REG_SR: begin
                    DOut[SR_IM_LSB +: 6] = sr_im_q;
                    DOut[SR_EXL_BIT]     = sr_exl_q;
                    DOut[SR_IE_BIT]      = sr_ie_q;
                end
                CP0_REG_CAUSE: begin
                    DOut[CAUSE_BD_BIT]         = cause_bd_q;
                    DOut[CAUSE_IP_LSB +: 6]    = cause_ip_q;
                    DOut[CAUSE_EXC_LSB +: 5]   = cause_exc_q;
                end
                CP0_REG_EPC: DOut = {epc_q, 2'b00};
`ifdef CP0_PRID_EN
                CP0_REG_PRID: DOut = PRID_VALUE;
`endif
                default: ;
            endcase
        end
    end

    assign EPCOut = {epc_q, 2'b00};

    // Low address bits are discarded by design.
`ifdef CP0_PRID_EN
    logic unused_bits;
    assign unused_bits = ^{DIn[1:0], PC[1:0], exc_req};
`else
    logic unused_bits;
    assign unused_bits = ^{DIn[1:0], PC[1:0], exc_req, PRID_VALUE};
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    int tests;
    int fails;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PC        (PC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .DOut      (DOut),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eret_idle();
        HWInt = 6'd0; ExcCodeIn = 5'd0; WE = 1'b0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; HWInt = 6'h3F; ExcCodeIn = 5'd12; WE = 1'b0; EXLClr = 1'b0;
        A1 = 5'd12; A2 = 5'd0; DIn = 32'd0; PC = 32'h3000; BDIn = 1'b0;
        tick();
        #1;
        tests++; if (Req !== 1'b0) begin fails++; $display("FAIL reset_req got %0b exp 0", Req); end
        tests++; if (DOut !== 32'd0) begin fails++; $display("FAIL reset_sr got %h exp 0", DOut); end
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'd0) begin fails++; $display("FAIL reset_cause got %h exp 0", DOut); end
        A1 = 5'd14; #1;
        tests++; if (DOut !== 32'd0) begin fails++; $display("FAIL reset_epc got %h exp 0", DOut); end
        reset = 1'b0; HWInt = 6'd0; ExcCodeIn = 5'd0;
        tick();
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'd0) begin fails++; $display("FAIL post_reset_cause got %h exp 0", DOut); end
        tests++; if (EPCOut !== 32'd0) begin fails++; $display("FAIL post_reset_epc got %h exp 0", EPCOut); end
    endtask

    task automatic test_interrupt();
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        #1;
        tests++; if (Req !== 1'b0) begin fails++; $display("FAIL mtc0_sr_req got %0b exp 0", Req); end
        tick();
        WE = 1'b0; A1 = 5'd12; #1;
        tests++; if (DOut !== 32'h0000_FC01) begin fails++; $display("FAIL mtc0_sr got %h exp 0000fc01", DOut); end
        HWInt = 6'b000100; PC = 32'h3010; BDIn = 1'b0; #1;
        tests++; if (Req !== 1'b1) begin fails++; $display("FAIL int_req got %0b exp 1", Req); end
        tick();
        #1;
        tests++; if (EPCOut !== 32'h3010) begin fails++; $display("FAIL int_epc got %h exp 00003010", EPCOut); end
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'h0000_1000) begin fails++; $display("FAIL int_cause got %h exp 00001000", DOut); end
        A1 = 5'd12; #1;
        tests++; if (DOut !== 32'h0000_FC03) begin fails++; $display("FAIL int_sr got %h exp 0000fc03", DOut); end
        tests++; if (Req !== 1'b0) begin fails++; $display("FAIL exl_masks_int got %0b exp 0", Req); end
        // Nested exception while EXL=1 must be ignored.
        ExcCodeIn = 5'd12; PC = 32'h3050; #1;
        tests++; if (Req !== 1'b0) begin fails++; $display("FAIL exl_masks_exc got %0b exp 0", Req); end
        tick();
        ExcCodeIn = 5'd0; #1;
        tests++; if (EPCOut !== 32'h3010) begin fails++; $display("FAIL nested_epc got %h exp 00003010", EPCOut); end
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'h0000_1000) begin fails++; $display("FAIL nested_cause got %h exp 00001000", DOut); end
    endtask

    task automatic test_exception_bd();
        eret_idle();
        A1 = 5'd12; #1;
        tests++; if (DOut !== 32'h0000_FC01) begin fails++; $display("FAIL eret_sr got %h exp 0000fc01", DOut); end
        ExcCodeIn = 5'd12; PC = 32'h3024; BDIn = 1'b1; #1;
        tests++; if (Req !== 1'b1) begin fails++; $display("FAIL exc_req got %0b exp 1", Req); end
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0; #1;
        tests++; if (EPCOut !== 32'h3020) begin fails++; $display("FAIL bd_epc got %h exp 00003020", EPCOut); end
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'h8000_0030) begin fails++; $display("FAIL bd_cause got %h exp 80000030", DOut); end
    endtask

    task automatic test_write_collision();
        eret_idle();
        WE = 1'b1; A2 = 5'd14; DIn = 32'h5000; ExcCodeIn = 5'd10; PC = 32'h3000; #1;
        tests++; if (Req !== 1'b1) begin fails++; $display("FAIL coll_req got %0b exp 1", Req); end
        tick();
        WE = 1'b0; ExcCodeIn = 5'd0; #1;
        tests++; if (EPCOut !== 32'h3000) begin fails++; $display("FAIL coll_epc got %h exp 00003000", EPCOut); end
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'h0000_0028) begin fails++; $display("FAIL coll_cause got %h exp 00000028", DOut); end
        // Plain mtc0 EPC: low two bits dropped.
        WE = 1'b1; A2 = 5'd14; DIn = 32'h5003;
        tick();
        WE = 1'b0; #1;
        tests++; if (EPCOut !== 32'h5000) begin fails++; $display("FAIL mtc0_epc got %h exp 00005000", EPCOut); end
        // Cause is read-only.
        WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0; A1 = 5'd13; #1;
        tests++; if (DOut !== 32'h0000_0028) begin fails++; $display("FAIL cause_ro got %h exp 00000028", DOut); end
    endtask

    task automatic test_eret();
        HWInt = 6'b000001; PC = 32'h3200; BDIn = 1'b0; #1;
        tests++; if (Req !== 1'b0) begin fails++; $display("FAIL pend_masked got %0b exp 0", Req); end
        EXLClr = 1'b1;
        tick();
        A1 = 5'd12; #1;
        tests++; if (DOut !== 32'h0000_FC01) begin fails++; $display("FAIL eret_clr got %h exp 0000fc01", DOut); end
        tests++; if (Req !== 1'b1) begin fails++; $display("FAIL pend_req got %0b exp 1", Req); end
        // EXLClr still high alongside Req: Req wins.
        tick();
        EXLClr = 1'b0; HWInt = 6'd0; #1;
        tests++; if (DOut !== 32'h0000_FC03) begin fails++; $display("FAIL eret_vs_req got %h exp 0000fc03", DOut); end
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'h0000_0400) begin fails++; $display("FAIL eret_cause got %h exp 00000400", DOut); end
        tests++; if (EPCOut !== 32'h3200) begin fails++; $display("FAIL eret_epc got %h exp 00003200", EPCOut); end
    endtask

    task automatic test_bubble();
        eret_idle();
        HWInt = 6'b000010; PC = 32'h0000_4180; BDIn = 1'b0; #1;
        tests++; if (Req !== 1'b1) begin fails++; $display("FAIL bubble_req got %0b exp 1", Req); end
        tick();
        HWInt = 6'd0; #1;
        tests++; if (EPCOut !== 32'h0000_4180) begin fails++; $display("FAIL bubble_epc got %h exp 00004180", EPCOut); end
        A1 = 5'd13; #1;
        tests++; if (DOut !== 32'h0000_0800) begin fails++; $display("FAIL bubble_cause got %h exp 00000800", DOut); end
    endtask

    task automatic test_masks();
        eret_idle();
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC00;
        tick();
        WE = 1'b0; HWInt = 6'h3F; #1;
        tests++; if (Req !== 1'b0) begin fails++; $display("FAIL ie_mask got %0b exp 0", Req); end
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 1'b0; HWInt = 6'b111110; #1;
        tests++; if (Req !== 1'b0) begin fails++; $display("FAIL im_mask got %0b exp 0", Req); end
        HWInt = 6'b000001; #1;
        tests++; if (Req !== 1'b1) begin fails++; $display("FAIL im_pass got %0b exp 1", Req); end
        HWInt = 6'd0; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0000;
        tick();
        WE = 1'b0; ExcCodeIn = 5'd5; #1;
        tests++; if (Req !== 1'b1) begin fails++; $display("FAIL exc_ignores_ie got %0b exp 1", Req); end
        ExcCodeIn = 5'd0; #1;
    endtask

    task automatic test_prid();
        A1 = 5'd15; #1;
`ifdef CP0_PRID_EN
        tests++; if (DOut !== 32'h4A55_4C59) begin fails++; $display("FAIL prid got %h exp 4a554c59", DOut); end
`else
        tests++; if (DOut !== 32'd0) begin fails++; $display("FAIL prid got %h exp 00000000", DOut); end
`endif
        A1 = 5'd0; #1;
        tests++; if (DOut !== 32'd0) begin fails++; $display("FAIL unimpl_reg got %h exp 00000000", DOut); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_write_collision();
        test_eret();
        test_bubble();
        test_masks();
        test_prid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
